instr_controller: RTL and testbench
===================================

# instr_controller

Instruction register, decoder and control state machine for the simple 16-bit CPU. It latches a 16-bit instruction and produces the sign-extended immediates. It sequences the datapath one micro-step per clock by driving register addresses, load enables and mux selects. It sits directly upstream of the datapath and is the only master of its control inputs.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears state and instruction register
- in  in  16  instruction word
- load  in  1  instruction-register load strobe
- s  in  1  start execution (level-sampled)
- w  out  1  1 when idle in WAIT
- err  out  1  illegal-opcode flag (only with INSTR_CTRL_TRAP_EN; else tied 0)
- sximm5  out  16  sign-extended IR[4:0]
- sximm8  out  16  sign-extended IR[7:0]
- readnum, writenum  out  3 each  regfile addresses
- write, loada, loadb, loadc, loads, asel, bsel  out  1 each  datapath controls
- vsel  out  2  00 datapath_out, 01 PC, 10 sximm8, 11 mdata
- ALUop  out  2  ALU operation
- shift  out  2  shifter control

## Operation
- IR fields: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0].
- Instruction set:
  - MOV Rn,#imm8 = 110/10.
  - MOV Rd,Rm{,sh} = 110/00.
  - ADD = 101/00, CMP = 101/01, AND = 101/10, MVN = 101/11.
  - Any other opcode/op pair is illegal.
- IR loads `in` on a clock edge with load=1, only in WAIT. In any other state load is ignored.
- Outputs are Moore decode of state plus IR.
  - Every strobe not listed for a state is 0.
  - Defaults: asel=0, bsel=0, vsel=00, ALUop=op, shift=sh.
- States and transitions:
  - WAIT: w=1. Goes to DECODE if s=1.
  - DECODE: branches as follows.
    - MOV imm → WRITE_IMM.
    - MOV reg or MVN → GET_B.
    - ADD, AND or CMP → GET_A.
    - Illegal → WAIT (or TRAP, see Configuration).
  - WRITE_IMM: writenum=Rn, vsel=10, write=1. Next WAIT.
  - GET_A: readnum=Rn, loada=1. Next GET_B.
  - GET_B: readnum=Rm, loadb=1. Next COMPUTE.
  - COMPUTE: bsel=0. Next WAIT for CMP, else WRITE_REG.
    - MOV reg: asel=1, ALUop=00, loadc=1.
    - ADD/AND/MVN: asel=0, loadc=1.
    - CMP: ALUop=01, loads=1, loadc=0.
  - WRITE_REG: writenum=Rd, vsel=00, write=1. Next WAIT.
- readnum/writenum are 0 in states that do not use them.
- sximm5/sximm8 are always driven from IR, independent of state.
- Sign extension replicates IR[4] (sximm5) or IR[7] (sximm8) into the upper bits.

## Timing
- Reset values: state WAIT, IR=0x0000, w=1, err=0, all strobes 0, vsel=00, ALUop=00, shift=00, sximm5=sximm8=0.
- Reset is asynchronous. Asserting it mid-instruction returns to WAIT and drops write the same cycle; no partial register write occurs afterwards.
- Latency is counted in rising edges from the edge that samples s=1 until w=1 again:
  - MOV imm: 3
  - MOV reg: 5
  - MVN: 5
  - CMP: 5
  - ADD/AND: 6
  - Illegal: 2
- Every strobe is exactly one cycle wide per instruction.
- load and s both 1 in WAIT: the IR captures the new word on the same edge that enters DECODE, so the new instruction executes.
- If s is still 1 when WAIT is re-entered, the next execution starts on the following edge (no edge detection).
- w falls on the edge that leaves WAIT.

## Configuration
- INSTR_CTRL_TRAP_EN defined:
  - An illegal instruction in DECODE enters TRAP.
  - In TRAP, err=1, w=0 and all strobes are 0.
  - s and load are ignored in TRAP; only reset exits it.
- INSTR_CTRL_TRAP_EN undefined:
  - There is no TRAP state; illegal instructions return to WAIT.
  - err is constant 0.

## Test plan
- MOV R0,#7: load in=0xD007, then s.
  - Expect sximm8=0x0007 and one cycle of writenum=0, vsel=10, write=1.
  - w=1 three edges after s.
- MOV R1,#-2: in=0xD1FE.
  - Expect sximm8=0xFFFE and writenum=1 during the write cycle.
- ADD R2,R1,R0,LSL#1: in=0xA148. Expect the successive cycles:
  - readnum=1 with loada.
  - readnum=0 with loadb, shift=01.
  - ALUop=00 with loadc.
  - writenum=2 with write.
  - w=1 six edges after s.
- CMP R0,R1: in=0xA801.
  - Expect ALUop=01 with one loads pulse and write never asserted; w=1 after five edges.
  - Then load=1 while busy must leave the IR at 0xA801.
- Reset asserted during GET_B of ADD:
  - Immediately w=1, write=0, IR=0x0000.
  - A following s (illegal opcode 000) returns to WAIT in 2 edges with no strobes.
- Illegal in=0xE000 with INSTR_CTRL_TRAP_EN:
  - err=1, w=0, held through 10 cycles of s=1.
  - Cleared only by reset.
  - Without the macro, w=1 after 2 edges and err=0.

Source files
------------

// File: rtl/instr_controller.sv
// instr_controller: instruction register, decoder and Moore control FSM
// for the 16-bit CPU datapath. One micro-step per clock.
// Optional feature macro: INSTR_CTRL_TRAP_EN (illegal opcodes lock in TRAP
// with err=1 until reset; otherwise they return to WAIT and err is 0).
module instr_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic        err,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  ALUop,
  output logic [1:0]  shift
);
  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_COMPUTE, S_WRITE_REG
`ifdef INSTR_CTRL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q;

  // IR fields
  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  logic is_movi, is_movr, is_alu, is_cmp, is_mvn;
  assign is_movi = (opcode == 3'b110) && (op == 2'b10);
  assign is_movr = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu  = (opcode == 3'b101);
  assign is_cmp  = is_alu && (op == 2'b01);
  assign is_mvn  = is_alu && (op == 2'b11);

  // Immediates are pure functions of the IR, independent of state
  assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};
  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};

  // State register and IR; IR only accepts a new word while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (load && state_q == S_WAIT) ir_q <= in;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d  = state_q;
    w        = 1'b0;
    err      = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = 2'b00;
    ALUop    = op;
    shift    = sh;
    case (state_q)
      S_WAIT: begin
        w = 1'b1;
        if (s) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_movi)                state_d = S_WRITE_IMM;
        else if (is_movr || is_mvn) state_d = S_GET_B;
        else if (is_alu)            state_d = S_GET_A;
`ifdef INSTR_CTRL_TRAP_EN
        else                        state_d = S_TRAP;
`else
        else                        state_d = S_WAIT;
`endif
      end
      S_WRITE_IMM: begin
        writenum = rn;
        vsel     = 2'b10;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = S_GET_B;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
        state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (is_movr) begin
          asel  = 1'b1;
          ALUop = 2'b00;
          loadc = 1'b1;
        end else if (is_cmp) begin
          ALUop = 2'b01;
          loads = 1'b1;
        end else begin
          loadc = 1'b1;
        end
        state_d = is_cmp ? S_WAIT : S_WRITE_REG;
      end
      S_WRITE_REG: begin
        writenum = rd;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
`ifdef INSTR_CTRL_TRAP_EN
      S_TRAP: begin
        err     = 1'b1;
        state_d = S_TRAP;
      end
`endif
      default: state_d = S_WAIT;
    endcase
  end
endmodule

// File: tb/tb_instr_controller.sv
// Scoreboard bench for instr_controller: each instruction's expected
// per-cycle control word is queued when it is issued and popped/compared
// on every falling edge while the DUT steps through it.
module tb_instr_controller;
  logic        clk = 1'b0, reset = 1'b1, load = 1'b0, s = 1'b0;
  logic [15:0] in = 16'h0000;
  logic        w, err, write, loada, loadb, loadc, loads, asel, bsel;
  logic [15:0] sximm5, sximm8;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, ALUop, shift;

  typedef struct packed {
    logic w, err; logic [2:0] rn, wn;
    logic wr, la, lb, lc, ls, as, bs;
    logic [1:0] vs, alu, sh;
  } ctl_t;

  ctl_t obs;
  assign obs = {w, err, readnum, writenum, write, loada, loadb, loadc, loads,
                asel, bsel, vsel, ALUop, shift};

  ctl_t exp_q[$];
  int   n_cmp = 0, n_bad = 0;

  instr_controller dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .s(s),
    .w(w), .err(err), .sximm5(sximm5), .sximm8(sximm8),
    .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .ALUop(ALUop), .shift(shift)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Expected control-word sequence from DECODE until back in WAIT
  function automatic int push_trace(input logic [15:0] ir);
    ctl_t b, t;
    int n = 0;
    logic [2:0] opc = ir[15:13];
    logic [1:0] op  = ir[12:11];
    b = '0; b.alu = op; b.sh = ir[4:3];
    exp_q.push_back(b); n++;
    if (opc == 3'b110 && op == 2'b10) begin
      t = b; t.wn = ir[10:8]; t.vs = 2'b10; t.wr = 1'b1; exp_q.push_back(t); n++;
    end else if ((opc == 3'b110 && op == 2'b00) || opc == 3'b101) begin
      if (opc == 3'b101 && op != 2'b11) begin
        t = b; t.rn = ir[10:8]; t.la = 1'b1; exp_q.push_back(t); n++;
      end
      t = b; t.rn = ir[2:0]; t.lb = 1'b1; exp_q.push_back(t); n++;
      t = b;
      if (opc == 3'b110) begin t.as = 1'b1; t.alu = 2'b00; t.lc = 1'b1; end
      else if (op == 2'b01) begin t.alu = 2'b01; t.ls = 1'b1; end
      else t.lc = 1'b1;
      exp_q.push_back(t); n++;
      if (!(opc == 3'b101 && op == 2'b01)) begin
        t = b; t.wn = ir[7:5]; t.wr = 1'b1; exp_q.push_back(t); n++;
      end
    end else begin
`ifdef INSTR_CTRL_TRAP_EN
      t = b; t.err = 1'b1;
      for (int i = 0; i < 11; i++) begin exp_q.push_back(t); n++; end
      return n;
`endif
    end
    t = b; t.w = 1'b1; exp_q.push_back(t); n++;
    return n;
  endfunction

  // Issue ir (load+s together) and walk the scoreboard. reps>1 keeps s high
  // so WAIT immediately restarts; busy_load strobes load with another word
  // while the instruction is in flight.
  task automatic run(input logic [15:0] ir, input int reps, input bit keep_s,
                     input bit busy_load);
    int L = 0, k = 0;
    ctl_t e;
    for (int r = 0; r < reps; r++) L = push_trace(ir);
    in = ir; load = 1'b1; s = 1'b1;
    while (exp_q.size() > 0) begin
      @(negedge clk); k++;
      e = exp_q.pop_front();
      chk($sformatf("ctl[%0d] ir=%h", k, ir), 32'(obs), 32'(e));
      if (k == 1) begin
        chk($sformatf("sximm8 ir=%h", ir), 32'(sximm8), 32'({{8{ir[7]}}, ir[7:0]}));
        chk($sformatf("sximm5 ir=%h", ir), 32'(sximm5), 32'({{11{ir[4]}}, ir[4:0]}));
      end
      s = keep_s || (exp_q.size() >= L);
      if (busy_load && (k == 2 || k == 3)) begin load = 1'b1; in = 16'hD0FF; end
      else begin load = 1'b0; in = ir; end
    end
    chk($sformatf("ir_hold ir=%h", ir), 32'(sximm8), 32'({{8{ir[7]}}, ir[7:0]}));
    load = 1'b0; s = 1'b0;
  endtask

  task automatic do_reset();
    ctl_t rv;
    rv = '0; rv.w = 1'b1;
    reset = 1'b1;
    #1;
    chk("reset ctl", 32'(obs), 32'(rv));
    chk("reset sximm8", 32'(sximm8), 32'h0);
    chk("reset sximm5", 32'(sximm5), 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    ctl_t gb;
    repeat (2) @(negedge clk);
    do_reset();
    run(16'hD007, 1, 1'b0, 1'b0);   // MOV R0,#7
    run(16'hD1FE, 1, 1'b0, 1'b0);   // MOV R1,#-2
    run(16'hA148, 1, 1'b0, 1'b0);   // ADD R2,R1,R0,LSL#1
    run(16'hA801, 1, 1'b0, 1'b1);   // CMP R0,R1 with load while busy
    run(16'hC053, 1, 1'b0, 1'b0);   // MOV R2,R3,LSR
    run(16'hB869, 1, 1'b0, 1'b0);   // MVN R3,R1,LSL
    run(16'hB283, 1, 1'b0, 1'b0);   // AND R4,R2,R3
    run(16'hD3F0, 2, 1'b0, 1'b0);   // MOV R3,#-16 twice, s held

    // Reset during GET_B of ADD
    in = 16'hA148; load = 1'b1; s = 1'b1;
    @(negedge clk); load = 1'b0; s = 1'b0;
    @(negedge clk);
    @(negedge clk);
    gb = '0; gb.rn = 3'd0; gb.lb = 1'b1; gb.sh = 2'b01;
    chk("pre-reset GET_B", 32'(obs), 32'(gb));
    do_reset();
    run(16'h0000, 1, 1'b0, 1'b0);   // IR cleared: illegal opcode 000
`ifdef INSTR_CTRL_TRAP_EN
    do_reset();
    run(16'hE000, 1, 1'b1, 1'b1);   // trap held under s/load
    do_reset();
`else
    run(16'hE000, 1, 1'b0, 1'b0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
